// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle non-restoring integer divider that produces one quotient bit per
// clock. Operands are signed (two's complement) or unsigned, selected per
// operation. Signed results truncate toward zero, and the remainder takes the
// sign of the dividend.
//
// Parameters:
//   WIDTH        operand/result width in bits (>= 2)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-high
//   start        request a division (sampled only in IDLE)
//   abort        (only with SEQ_DIVIDER_ABORT_EN) cancel an operation in DIV/FIX
//   signed_mode  1 = two's-complement operands, 0 = unsigned (latched with start)
//   dividend     dividend (latched with start)
//   divisor      divisor (latched with start)
//   busy         high while an operation is in DIV or FIX
//   done         single-cycle completion pulse
//   quotient     quotient of the last completed operation
//   remainder    remainder of the last completed operation
//   div_by_zero  last completed operation had a zero divisor
//   overflow     last completed operation was signed MIN / -1
//
// Optional feature macro: SEQ_DIVIDER_ABORT_EN (adds the abort input).
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SEQ_DIVIDER_ABORT_EN
    input  logic             abort,
`endif
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int               CW      = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_VAL = ~MIN_VAL;
    localparam logic [WIDTH-1:0] ONES    = '1;

    typedef enum logic [1:0] {IDLE, DIV, FIX, FIN} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            count_q;
    logic signed [WIDTH:0]    prem_q;
    logic [WIDTH-1:0]         quo_q;
    logic [WIDTH-1:0]         dmag_q;
    logic                     negate_quo, negate_rem;

    logic                     div_zero, div_ovf, abort_req;
    logic signed [WIDTH:0]    prem_shift, prem_step;
    logic [WIDTH-1:0]         rem_mag;

    // Magnitude of an operand; in unsigned mode the raw bits already are one.
    // abs(MIN) wraps to MIN, which read as unsigned is the correct magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic            is_signed);
        return (is_signed && x[WIDTH-1]) ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x,
                                                    input logic            neg);
        return neg ? -x : x;
    endfunction

`ifdef SEQ_DIVIDER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign div_zero = (divisor == '0);
    assign div_ovf  = signed_mode && (dividend == MIN_VAL) && (divisor == ONES);

    // One non-restoring step. The sign of the current partial remainder picks
    // subtract or add; a negative value stands for the unrestored remainder.
    // The W+1-bit result always lies in [-D, D), so modular wrap is harmless.
    assign prem_shift = {prem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign prem_step  = prem_q[WIDTH] ? (prem_shift + $signed({1'b0, dmag_q}))
                                      : (prem_shift - $signed({1'b0, dmag_q}));

    // Final restore of a negative partial remainder; the sum fits in WIDTH bits.
    assign rem_mag = prem_q[WIDTH] ? (prem_q[WIDTH-1:0] + dmag_q) : prem_q[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (div_zero || div_ovf) ? FIN : DIV;
            end
            DIV: begin
                busy = 1'b1;
                if (abort_req)                  state_d = IDLE;
                else if (count_q == CW'(1))     state_d = FIX;
            end
            FIX: begin
                busy    = 1'b1;
                state_d = abort_req ? IDLE : FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (state_q == IDLE && start) begin
            count_q <= CW'(WIDTH);
        end else if (state_q == DIV) begin
            count_q <= count_q - CW'(1);
        end
    end

    // Datapath registers carry no reset; they are always reloaded on start.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            prem_q     <= '0;
            quo_q      <= magnitude(dividend, signed_mode);
            dmag_q     <= magnitude(divisor, signed_mode);
            negate_quo <= signed_mode && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            negate_rem <= signed_mode && dividend[WIDTH-1];
        end else if (state_q == DIV) begin
            prem_q <= prem_step;
            quo_q  <= {quo_q[WIDTH-2:0], ~prem_step[WIDTH]};
        end
    end

    // Result registers: updated on the edge into FIN so they are valid with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (state_q == IDLE && start && div_zero) begin
                quotient    <= '0;
                remainder   <= '0;
                div_by_zero <= 1'b1;
                overflow    <= 1'b0;
            end else if (state_q == IDLE && start && div_ovf) begin
                quotient    <= MAX_VAL;
                remainder   <= '0;
                div_by_zero <= 1'b0;
                overflow    <= 1'b1;
            end else if (state_q == FIX && !abort_req) begin
                quotient    <= apply_sign(quo_q, negate_quo);
                remainder   <= apply_sign(rem_mag, negate_rem);
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Scoreboard bench for seq_divider (WIDTH=8). The driver pushes the expected
// result of every accepted operation; a monitor pops and compares on done and
// otherwise checks that the result outputs hold their last value.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W = 8;
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAXV = ~MINV;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           lat;
        int           t0;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] dividend, divisor;
    logic         busy, done;
    logic [W-1:0] quotient, remainder;
    logic         div_by_zero, overflow;
`ifdef SEQ_DIVIDER_ABORT_EN
    logic         abort;
`endif

    exp_t expq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    logic [W-1:0] held_q, held_r;
    logic         held_dbz, held_ovf;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
`ifdef SEQ_DIVIDER_ABORT_EN
        .abort       (abort),
`endif
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic. SystemVerilog '/' and '%'
    // truncate toward zero with the remainder following the dividend.
    function automatic exp_t model(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sa, sbv;
        e.t0 = 0;
        if (b == '0) begin
            e.q = '0; e.r = '0; e.dbz = 1'b1; e.ovf = 1'b0; e.lat = 1;
        end else if (sm && a == MINV && b == '1) begin
            e.q = MAXV; e.r = '0; e.dbz = 1'b0; e.ovf = 1'b1; e.lat = 1;
        end else begin
            if (sm) begin
                sa  = $signed(a);
                sbv = $signed(b);
            end else begin
                sa  = int'(a);
                sbv = int'(b);
            end
            e.q = W'(sa / sbv); e.r = W'(sa % sbv);
            e.dbz = 1'b0; e.ovf = 1'b0; e.lat = W + 2;
        end
        return e;
    endfunction

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("reset_outputs", {busy, done, quotient, remainder, div_by_zero, overflow}, '0);
            held_q = '0; held_r = '0; held_dbz = 1'b0; held_ovf = 1'b0;
        end else if (done) begin
            if (expq.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                e = expq.pop_front();
                chk("quotient",    quotient,    e.q);
                chk("remainder",   remainder,   e.r);
                chk("div_by_zero", div_by_zero, e.dbz);
                chk("overflow",    overflow,    e.ovf);
                chk("latency",     cyc - e.t0,  e.lat);
                chk("busy_at_done", busy, 1'b0);
                held_q = e.q; held_r = e.r; held_dbz = e.dbz; held_ovf = e.ovf;
            end
        end else begin
            chk("outputs_hold", {quotient, remainder, div_by_zero, overflow},
                {held_q, held_r, held_dbz, held_ovf});
        end
    end

    // Called just after a rising edge with the DUT in IDLE. Returns one cycle
    // after done, again just after a rising edge.
    task automatic issue(input bit sm, input int a, input int b,
                         input int busy_start, input bit fin_start);
        exp_t e;
        int   nb;
        bit   seen;
        start = 1'b1; signed_mode = sm; dividend = W'(a); divisor = W'(b);
        e = model(sm, W'(a), W'(b));
        e.t0 = cyc;
        expq.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; signed_mode = 1'($urandom_range(0, 1));
        dividend = W'($urandom); divisor = W'($urandom);
        nb = 0; seen = 0;
        for (int i = 0; i < 4 * W + 10 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                if (fin_start) begin
                    start = 1'b1; dividend = W'($urandom); divisor = W'($urandom);
                end
            end else begin
                if (busy) nb++;
                if (i == busy_start) begin
                    start = 1'b1; dividend = W'($urandom); divisor = W'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", 4 * W + 10);
            expq.delete();
        end else begin
            chk("busy_cycles", nb, (e.lat == 1) ? 0 : W + 1);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        int a, b, bs, n;
        bit fs, sm;
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
`ifdef SEQ_DIVIDER_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        issue(1, 19, 4, -1, 0);
        issue(1, -19, 4, -1, 0);
        issue(1, 100, -7, -1, 0);
        issue(1, -128, -1, -1, 0);
        issue(0, 128, 255, -1, 0);
        issue(1, 50, 0, -1, 0);
        issue(0, 50, 0, -1, 0);
        issue(1, 16, 4, -1, 0);
        issue(0, 255, 1, -1, 0);
        issue(0, 200, 7, 2, 1);

        // Asynchronous reset in the middle of DIV: no done may follow.
        start = 1'b1; signed_mode = 1'b0; dividend = 8'd200; divisor = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_async", {busy, done, quotient, remainder, div_by_zero, overflow}, '0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(1, -127, 5, -1, 0);

`ifdef SEQ_DIVIDER_ABORT_EN
        issue(1, 16, 4, -1, 0);
        start = 1'b1; signed_mode = 1'b1; dividend = 8'd127; divisor = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle", busy, 1'b0);
        repeat (15) @(posedge clk);
        #1 chk("abort_stays_idle", busy, 1'b0);
        chk("abort_keeps_q", quotient, 8'd4);
        chk("abort_keeps_r", remainder, 8'd0);
`endif

        for (int k = 0; k < 300; k++) begin
            sm = 1'($urandom_range(0, 1));
            a  = int'($urandom);
            b  = int'($urandom);
            case ($urandom_range(0, 19))
                0: b = 0;
                1: begin sm = 1'b1; a = int'(MINV); b = -1; end
                2: b = 1;
                3: b = -1;
                default: ;
            endcase
            bs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W)) : -1;
            fs = ($urandom_range(0, 3) == 0);
            issue(sm, a, b, bs, fs);
            n = int'($urandom_range(0, 2));
            if (n > 0) begin
                repeat (n) @(posedge clk);
                #1;
            end
        end

        repeat (5) @(posedge clk);
        #1 chk("queue_drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Parametrised multi-cycle non-restoring integer divider, successor to the 8-bit combinational divider in the ALU.
- Computes one quotient bit per clock.
- Supports signed or unsigned operands, selectable per operation.
- Uses a start/busy/done handshake so it can sit behind the ALU operation decoder without lengthening the critical path.
- Signed results truncate toward zero; the remainder takes the sign of the dividend, matching the existing divider.

Parameters:
WIDTH, 8, operand and result width in bits (minimum 2).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  request a division; sampled only while busy=0
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; latched with start
dividend  input  WIDTH  dividend; latched with start
divisor  input  WIDTH  divisor; latched with start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  single-cycle pulse; results valid from this cycle onward
quotient  output  WIDTH  quotient, held until the next completion
remainder  output  WIDTH  remainder, held until the next completion
div_by_zero  output  1  flag for the last completed operation
overflow  output  1  flag for the last completed operation (signed MIN / -1)

Behaviour:
- Reset (asynchronous, any time):
  - state=IDLE.
  - busy, done, quotient, remainder, div_by_zero and overflow all 0.
  - Any in-flight operation is discarded and produces no done.
- States: IDLE, DIV, FIX, FIN.
- IDLE:
  - start=1 latches the operands and mode; busy rises on the next cycle.
  - If divisor==0, go to FIN with a zero-divide result.
  - Else, if signed_mode=1 and dividend==MIN (1 followed by zeros) and divisor==all-ones, go to FIN with an overflow result.
  - Otherwise load magnitudes: abs() in signed mode, raw in unsigned mode. Zero the WIDTH+1-bit partial remainder, set count=WIDTH, go to DIV.
- DIV, one step per cycle:
  - Shift {partial remainder, quotient reg} left by one.
  - If the partial remainder is >=0, subtract the divisor magnitude; else add it.
  - New quotient bit = ~sign of the new partial remainder.
  - Decrement count; when the count reaches 0 after this step, go to FIX.
- FIX:
  - If the partial remainder is <0, add the divisor magnitude.
  - In signed mode, negate the quotient if the operand signs differ, and negate the remainder if the dividend was negative.
  - Register quotient/remainder, clear both flags, go to FIN.
- FIN:
  - done=1 for exactly this cycle; busy=0 in this cycle; next state IDLE.
  - Zero-divide result: quotient=0, remainder=0, div_by_zero=1, overflow=0.
  - Overflow result: quotient=MAX (0 then all ones, i.e. 127 at WIDTH=8), remainder=0, overflow=1, div_by_zero=0.
- Latency, start sampled at edge 0:
  - Normal: done high after edge WIDTH+2, i.e. 10 cycles at WIDTH=8.
  - Zero-divide or overflow: done high after edge 1.
- start while busy=1 or during FIN: ignored, with no queuing. start is accepted again only in IDLE, so the earliest back-to-back start is sampled the cycle after done.
- Operand inputs may change freely after start is accepted.
- Outputs change only in FIX/FIN or on reset; they are stable between completions.
- Unsigned mode never sets overflow; unsigned MAX/1 = MAX, remainder 0.

Optional Feature:
Macro: SEQ_DIVIDER_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit, after start).
  - abort=1 in DIV or FIX returns to IDLE at the next edge.
  - No done pulse is issued, and quotient/remainder/flags keep their previous values.
  - abort is ignored in IDLE and FIN; abort and start together in IDLE are treated as start only.
- Not defined: the port does not exist, and every accepted operation runs to done.

Test Plan:
- WIDTH=8, signed: 19/4 -> quotient 4, remainder 3, done exactly 10 cycles after start, busy high 9 cycles. Then -19/4 -> -4,-3 and 100/-7 -> -14,2.
- Signed -128/-1 -> quotient 127, remainder 0, overflow=1, done 1 cycle after start. Unsigned 128/255 (same bits) -> quotient 0, remainder 128, overflow=0.
- 50/0 in both modes -> quotient 0, remainder 0, div_by_zero=1, done after 1 cycle. The following 16/4 completes normally with flags cleared.
- Unsigned 200/7 -> 28 r4. Second start pulsed 3 cycles later while busy -> ignored; result unchanged and only one done pulse.
- rst asserted asynchronously mid-DIV (cycle 5) -> all outputs 0 immediately, no done; a new -127/5 afterwards -> -25,-2.
- With SEQ_DIVIDER_ABORT_EN: abort in cycle 4 of 127/5 after a prior 16/4 -> no done; outputs remain 4/0 and the block returns to IDLE.
